// File: rtl/gbuff_burst_arbiter.sv
// gbuff_burst_arbiter: two-client round-robin arbiter and burst sequencer in front
// of a single-port global buffer (1-cycle registered read, exclusive read/write).
`default_nettype none
module gbuff_burst_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 c0_req,
  input  logic                 c0_we,
  input  logic [ADDR_BITS-1:0] c0_base,
  input  logic [LEN_BITS-1:0]  c0_len,
  output logic                 c0_gnt,
  input  logic [DATA_BITS-1:0] c0_wdata,
  input  logic                 c0_wvalid,
  output logic                 c0_wready,
  output logic [DATA_BITS-1:0] c0_rdata,
  output logic                 c0_rvalid,
  output logic                 c0_done,
  input  logic                 c1_req,
  input  logic                 c1_we,
  input  logic [ADDR_BITS-1:0] c1_base,
  input  logic [LEN_BITS-1:0]  c1_len,
  output logic                 c1_gnt,
  input  logic [DATA_BITS-1:0] c1_wdata,
  input  logic                 c1_wvalid,
  output logic                 c1_wready,
  output logic [DATA_BITS-1:0] c1_rdata,
  output logic                 c1_rvalid,
  output logic                 c1_done,
  output logic                 gb_wr_en,
  output logic [ADDR_BITS-1:0] gb_index,
  output logic [DATA_BITS-1:0] gb_data_in,
  input  logic [DATA_BITS-1:0] gb_data_out
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic                 gnt_q, gnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 done_q, done_d;

  logic                 in_burst;
  logic                 sel;
  logic                 owner_wvalid;
  logic [DATA_BITS-1:0] owner_wdata;
  logic                 fire;
  logic                 last_beat;

  assign in_burst     = (state_q == BURST);
  assign owner_wvalid = owner_q ? c1_wvalid : c0_wvalid;
  assign owner_wdata  = owner_q ? c1_wdata : c0_wdata;
  assign fire         = in_burst && (!we_q || owner_wvalid);
  assign last_beat    = fire && (cnt_q == len_q);
  // On a tie the client that did not own the previous burst wins.
  assign sel          = (c0_req && c1_req) ? ~last_q : c1_req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gnt_d    = 1'b0;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          owner_d = sel;
          we_d    = sel ? c1_we : c0_we;
          base_d  = sel ? c1_base : c0_base;
          len_d   = sel ? c1_len : c0_len;
          cnt_d   = '0;
          gnt_d   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        rvalid_d = !we_q;
        if (fire) begin
          cnt_d = cnt_q + LEN_BITS'(1);
        end
        if (last_beat) begin
          state_d = IDLE;
          last_d  = owner_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  // Index wraps naturally modulo DEPTH through the ADDR_BITS-wide add.
  assign gb_index   = in_burst ? (base_q + ADDR_BITS'(cnt_q)) : '0;
  assign gb_wr_en   = in_burst && we_q && owner_wvalid;
  assign gb_data_in = (in_burst && we_q) ? owner_wdata : '0;

  assign c0_gnt    = gnt_q && !owner_q;
  assign c1_gnt    = gnt_q && owner_q;
  assign c0_wready = gb_wr_en && !owner_q;
  assign c1_wready = gb_wr_en && owner_q;
  assign c0_rvalid = rvalid_q && !owner_q;
  assign c1_rvalid = rvalid_q && owner_q;
  assign c0_rdata  = c0_rvalid ? gb_data_out : '0;
  assign c1_rdata  = c1_rvalid ? gb_data_out : '0;
  assign c0_done   = done_q && !owner_q;
  assign c1_done   = done_q && owner_q;

endmodule
`default_nettype wire
